// File: rtl/msk_rx_pkg.sv
// Shared types and helpers for the MSK receiver carrier-recovery blocks.
package msk_rx_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        ACQUIRE = 3'd2,
        TRACK   = 3'd3,
        NARROW  = 3'd4
    } lock_state_t;

    typedef logic [1:0] gain_sel_t;

    localparam gain_sel_t GAIN_WIDE   = 2'd0;
    localparam gain_sel_t GAIN_MED    = 2'd1;
    localparam gain_sel_t GAIN_NARROW = 2'd2;

    // Bits needed to hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/lock_metric_acc.sv
// Windowed |phase error| accumulator: saturating abs, sample counter, registered window-done
// strobe with the completed sum.
module lock_metric_acc #(
    parameter int unsigned EW       = 24,
    parameter int unsigned WIN_LOG2 = 6
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clr,
    input  logic                     i_err_valid,
    input  logic signed [EW-1:0]     i_phase_err,
    output logic                     o_win_done,
    output logic [EW+WIN_LOG2-1:0]   o_win_sum
);

    localparam int unsigned SW = EW + WIN_LOG2;
    localparam int unsigned CW = WIN_LOG2 + 1;
    localparam logic [CW-1:0] WinLen = CW'(1) << WIN_LOG2;
    localparam logic [EW-1:0] MostNeg = {1'b1, {(EW - 1){1'b0}}};
    localparam logic [EW-1:0] MostPos = {1'b0, {(EW - 1){1'b1}}};

    logic [SW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_win_done;

    logic [EW-1:0] w_abs;
    logic [SW-1:0] w_acc_base;
    logic [SW-1:0] w_acc_inc;
    logic [CW-1:0] w_cnt_base;
    logic [CW-1:0] w_cnt_inc;

    always_comb begin
        if (i_phase_err == MostNeg) begin
            w_abs = MostPos;
        end else if (i_phase_err[EW-1]) begin
            w_abs = -i_phase_err;
        end else begin
            w_abs = i_phase_err;
        end
    end

    // In the win_done cycle the finished sum is consumed, so a new window starts from zero and
    // a coincident sample becomes its first entry.
    assign w_acc_base = r_win_done ? '0 : r_acc;
    assign w_cnt_base = r_win_done ? '0 : r_cnt;
    assign w_acc_inc  = w_acc_base + SW'(w_abs);
    assign w_cnt_inc  = w_cnt_base + CW'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_win_done <= 1'b0;
        end else if (i_err_valid) begin
            r_acc      <= w_acc_inc;
            r_cnt      <= w_cnt_inc;
            r_win_done <= (w_cnt_inc == WinLen);
        end else begin
            r_acc      <= w_acc_base;
            r_cnt      <= w_cnt_base;
            r_win_done <= 1'b0;
        end
    end

    assign o_win_done = r_win_done;
    assign o_win_sum  = r_acc;

endmodule

// File: rtl/carrier_lock_ctrl.sv
// Carrier-loop sequencer: gates the phase-detector strobe, schedules loop gain and reports lock.
// Define CARRIER_LOCK_STATS_EN to add the loss_cnt / win_metric debug ports.
module carrier_lock_ctrl
    import msk_rx_pkg::*;
#(
    parameter int unsigned EW          = 24,
    parameter int unsigned WIN_LOG2    = 6,
    parameter int unsigned SETTLE_SYMS = 16,
    parameter int unsigned LOCK_THR    = 2 ** 22,
    parameter int unsigned UNLOCK_THR  = 2 ** 24,
    parameter int unsigned LOCK_WINS   = 4,
    parameter int unsigned NARROW_WINS = 8,
    parameter int unsigned UNLOCK_WINS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   sym_valid_in,
    output logic                   sym_valid_out,
    input  logic                   err_valid,
    input  logic signed [EW-1:0]   phase_err,
    output logic                   loop_rst,
    output logic [1:0]             gain_sel,
    output logic                   lock,
`ifdef CARRIER_LOCK_STATS_EN
    output logic [15:0]            loss_cnt,
    output logic [EW+WIN_LOG2-1:0] win_metric,
`endif
    output logic [2:0]             state
);

    localparam int unsigned SW = EW + WIN_LOG2;
    localparam int unsigned GoodMaxV = (LOCK_WINS > NARROW_WINS) ? LOCK_WINS : NARROW_WINS;
    localparam int unsigned SCW = cnt_width(SETTLE_SYMS);
    localparam int unsigned GCW = cnt_width(GoodMaxV);
    localparam int unsigned BCW = cnt_width(UNLOCK_WINS);
    localparam logic [GCW-1:0] GoodMax = GCW'(GoodMaxV);
    localparam logic [BCW-1:0] BadMax  = BCW'(UNLOCK_WINS);

    lock_state_t    r_state;
    logic           r_pd_en;
    logic           r_loop_rst;
    logic           r_lock;
    gain_sel_t      r_gain_sel;
    logic [SCW-1:0] r_settle_cnt;
    logic [GCW-1:0] r_good_cnt;
    logic [BCW-1:0] r_bad_cnt;

    logic           w_run;
    logic           w_win_done;
    logic [SW-1:0]  w_sum;
    logic           w_eval;
    logic           w_good;
    logic           w_bad;
    logic [GCW-1:0] w_good_next;
    logic [BCW-1:0] w_bad_next;
    logic           w_unlock;

    assign w_run = (r_state == ACQUIRE) || (r_state == TRACK) || (r_state == NARROW);

    lock_metric_acc #(
        .EW       (EW),
        .WIN_LOG2 (WIN_LOG2)
    ) u_metric (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_clr       (~enable | ~w_run),
        .i_err_valid (err_valid),
        .i_phase_err (phase_err),
        .o_win_done  (w_win_done),
        .o_win_sum   (w_sum)
    );

    assign w_eval      = w_win_done & w_run & enable;
    assign w_good      = 64'(w_sum) < 64'(LOCK_THR);
    assign w_bad       = 64'(w_sum) > 64'(UNLOCK_THR);
    assign w_good_next = (r_good_cnt == GoodMax) ? r_good_cnt : r_good_cnt + GCW'(1);
    assign w_bad_next  = (r_bad_cnt == BadMax) ? r_bad_cnt : r_bad_cnt + BCW'(1);
    assign w_unlock    = w_eval && w_bad && (w_bad_next >= BadMax) &&
                         ((r_state == TRACK) || (r_state == NARROW));

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_state      <= IDLE;
            r_pd_en      <= 1'b0;
            r_loop_rst   <= 1'b1;
            r_lock       <= 1'b0;
            r_gain_sel   <= GAIN_WIDE;
            r_settle_cnt <= '0;
            r_good_cnt   <= '0;
            r_bad_cnt    <= '0;
        end else begin
            r_loop_rst <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_state      <= SETTLE;
                    r_pd_en      <= 1'b1;
                    r_settle_cnt <= '0;
                end
                SETTLE: begin
                    if (err_valid) begin
                        if (r_settle_cnt == SCW'(SETTLE_SYMS - 1)) begin
                            r_state      <= ACQUIRE;
                            r_settle_cnt <= '0;
                            r_good_cnt   <= '0;
                            r_bad_cnt    <= '0;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + SCW'(1);
                        end
                    end
                end
                ACQUIRE: begin
                    if (w_eval) begin
                        if (!w_good) begin
                            r_good_cnt <= '0;
                        end else if (w_good_next >= GCW'(LOCK_WINS)) begin
                            r_state    <= TRACK;
                            r_lock     <= 1'b1;
                            r_gain_sel <= GAIN_MED;
                            r_good_cnt <= '0;
                        end else begin
                            r_good_cnt <= w_good_next;
                        end
                    end
                end
                TRACK, NARROW: begin
                    if (w_unlock) begin
                        r_state      <= SETTLE;
                        r_lock       <= 1'b0;
                        r_gain_sel   <= GAIN_WIDE;
                        r_loop_rst   <= 1'b1;
                        r_settle_cnt <= '0;
                        r_good_cnt   <= '0;
                        r_bad_cnt    <= '0;
                    end else if (w_eval) begin
                        r_bad_cnt <= w_bad ? w_bad_next : '0;
                        // Good-window history only matters while still waiting to narrow.
                        if (r_state == TRACK) begin
                            if (!w_good) begin
                                r_good_cnt <= '0;
                            end else if (w_good_next >= GCW'(NARROW_WINS)) begin
                                r_state    <= NARROW;
                                r_gain_sel <= GAIN_NARROW;
                                r_good_cnt <= '0;
                            end else begin
                                r_good_cnt <= w_good_next;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef CARRIER_LOCK_STATS_EN
    logic [15:0]   r_loss_cnt;
    logic [SW-1:0] r_win_metric;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_loss_cnt   <= '0;
            r_win_metric <= '0;
        end else begin
            if (w_unlock && (r_loss_cnt != 16'hFFFF)) begin
                r_loss_cnt <= r_loss_cnt + 16'd1;
            end
            if (w_eval) begin
                r_win_metric <= w_sum;
            end
        end
    end

    assign loss_cnt   = r_loss_cnt;
    assign win_metric = r_win_metric;
`endif

    assign sym_valid_out = sym_valid_in & r_pd_en;
    assign loop_rst      = r_loop_rst;
    assign gain_sel      = r_gain_sel;
    assign lock          = r_lock;
    assign state         = r_state;

endmodule

// File: tb/tb_carrier_lock_ctrl.sv
// Scoreboard bench for carrier_lock_ctrl: a per-window reference model queues the expected
// sequence of (state, loop_rst, lock, gain_sel) changes and a monitor checks each observed change.
module tb_carrier_lock_ctrl;

    localparam int EW          = 24;
    localparam int WIN_LOG2    = 2;
    localparam int WIN_LEN     = 1 << WIN_LOG2;
    localparam int SETTLE_SYMS = 4;
    localparam int LOCK_THR    = 1000;
    localparam int UNLOCK_THR  = 4000;
    localparam int LOCK_WINS   = 2;
    localparam int NARROW_WINS = 3;
    localparam int UNLOCK_WINS = 2;
    localparam int GAP         = 20;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic                 sym_valid_in;
    logic                 sym_valid_out;
    logic                 err_valid;
    logic signed [EW-1:0] phase_err;
    logic                 loop_rst;
    logic [1:0]           gain_sel;
    logic                 lock;
    logic [2:0]           state;
`ifdef CARRIER_LOCK_STATS_EN
    logic [15:0]          loss_cnt;
    logic [EW+WIN_LOG2-1:0] win_metric;
`endif

    carrier_lock_ctrl #(
        .EW          (EW),
        .WIN_LOG2    (WIN_LOG2),
        .SETTLE_SYMS (SETTLE_SYMS),
        .LOCK_THR    (LOCK_THR),
        .UNLOCK_THR  (UNLOCK_THR),
        .LOCK_WINS   (LOCK_WINS),
        .NARROW_WINS (NARROW_WINS),
        .UNLOCK_WINS (UNLOCK_WINS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .sym_valid_in  (sym_valid_in),
        .sym_valid_out (sym_valid_out),
        .err_valid     (err_valid),
        .phase_err     (phase_err),
        .loop_rst      (loop_rst),
        .gain_sel      (gain_sel),
        .lock          (lock),
`ifdef CARRIER_LOCK_STATS_EN
        .loss_cnt      (loss_cnt),
        .win_metric    (win_metric),
`endif
        .state         (state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: modes use the state encoding 0 idle, 1 settle, 2 acquire, 3 track, 4 narrow.
    int     m_mode   = 0;
    int     m_settle = 0;
    int     m_n      = 0;
    int     m_good   = 0;
    int     m_bad    = 0;
    int     m_loss   = 0;
    longint m_sum    = 0;
    longint m_last   = 0;
    logic [6:0] exp_q[$];
    bit     exp_pd_en = 1'b0;

    function automatic logic [6:0] tup(input int st, input bit lr);
        logic [2:0] s3;
        logic [1:0] g;
        bit lk;
        s3 = st[2:0];
        lk = (st == 3) || (st == 4);
        g  = (st == 3) ? 2'd1 : ((st == 4) ? 2'd2 : 2'd0);
        return {s3, lr, lk, g};
    endfunction

    function automatic longint abs_sat(input int e);
        if (e == -(1 << (EW - 1))) return longint'((1 << (EW - 1)) - 1);
        return (e < 0) ? longint'(-e) : longint'(e);
    endfunction

    function automatic void end_window(input longint s);
        bit good_w;
        bit bad_w;
        m_last = s;
        good_w = s < LOCK_THR;
        bad_w  = s > UNLOCK_THR;
        if (m_mode == 2) begin
            m_good = good_w ? m_good + 1 : 0;
            if (m_good >= LOCK_WINS) begin
                m_mode = 3; m_good = 0; exp_q.push_back(tup(3, 1'b0));
            end
        end else begin
            m_bad = bad_w ? m_bad + 1 : 0;
            if (m_bad >= UNLOCK_WINS) begin
                m_mode = 1; m_good = 0; m_bad = 0; m_settle = 0; m_loss++;
                exp_q.push_back(tup(1, 1'b1));
                exp_q.push_back(tup(1, 1'b0));
            end else if (m_mode == 3) begin
                m_good = good_w ? m_good + 1 : 0;
                if (m_good >= NARROW_WINS) begin
                    m_mode = 4; m_good = 0; exp_q.push_back(tup(4, 1'b0));
                end
            end
        end
    endfunction

    function automatic void model_pulse(input int e);
        if (m_mode == 1) begin
            m_settle++;
            if (m_settle == SETTLE_SYMS) begin
                m_mode = 2; m_settle = 0; m_n = 0; m_sum = 0; m_good = 0; m_bad = 0;
                exp_q.push_back(tup(2, 1'b0));
            end
        end else if (m_mode >= 2) begin
            m_sum += abs_sat(e);
            m_n++;
            if (m_n == WIN_LEN) begin
                end_window(m_sum);
                m_sum = 0; m_n = 0;
            end
        end
    endfunction

    function automatic void model_enable(input bit v);
        if (!v && m_mode != 0) begin
            m_mode = 0; m_settle = 0; m_n = 0; m_sum = 0; m_good = 0; m_bad = 0;
            exp_q.push_back(tup(0, 1'b1));
        end else if (v && m_mode == 0) begin
            m_mode = 1; m_settle = 0;
            exp_q.push_back(tup(1, 1'b0));
        end
    endfunction

    function automatic int rand_err(input int cls);
        int m;
        case (cls)
            0:       m = int'($urandom_range(0, 240));
            1:       m = int'($urandom_range(300, 900));
            default: m = int'($urandom_range(1001, 2000));
        endcase
        return ($urandom_range(0, 1) == 1) ? -m : m;
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_err(input int e, input int gap);
        repeat (gap - 1) begin @(posedge clk); #1; end
        err_valid = 1'b1;
        phase_err = EW'(e);
        model_pulse(e);
        @(posedge clk); #1;
        err_valid = 1'b0;
        phase_err = EW'($urandom);
    endtask

    task automatic send_win_val(input int e);
        repeat (WIN_LEN) send_err(e, GAP);
    endtask

    task automatic send_win_cls(input int cls);
        repeat (WIN_LEN) send_err(rand_err(cls), GAP);
    endtask

    task automatic set_enable(input bit v);
        enable = v;
        @(posedge clk); #1;
        exp_pd_en = v;
        model_enable(v);
    endtask

    task automatic check_mode(input string name);
        repeat (2) begin @(posedge clk); #1; end
        chk({name, "_state"}, state, m_mode);
        chk({name, "_lock"}, lock, (m_mode == 3 || m_mode == 4));
        chk({name, "_gain"}, gain_sel, (m_mode == 3) ? 1 : ((m_mode == 4) ? 2 : 0));
    endtask

    bit mon_en    = 1'b0;
    bit sym_force = 1'b0;

    initial begin : sym_driver
        sym_valid_in = 1'b0;
        forever begin
            @(posedge clk); #1;
            sym_valid_in = sym_force | ($urandom_range(0, 1) == 1);
        end
    end

    initial begin : monitor
        logic [6:0] prev;
        logic [6:0] cur;
        logic [6:0] exp;
        int lr_len;
        prev   = '0;
        lr_len = 0;
        forever begin
            @(negedge clk);
            cur = {state, loop_rst, lock, gain_sel};
            if (mon_en) begin
                chk("sym_valid_out", sym_valid_out, sym_valid_in & exp_pd_en);
                if (cur != prev) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_change: got %h expected no change", cur);
                    end else begin
                        exp = exp_q.pop_front();
                        chk("transition", cur, exp);
                    end
                end
                if (state == 3'd1 && loop_rst) begin
                    lr_len++;
                end else if (lr_len != 0) begin
                    chk("loop_rst_pulse_len", lr_len, 1);
                    lr_len = 0;
                end
            end
            prev = cur;
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst = 1'b1; enable = 1'b0; err_valid = 1'b0; phase_err = '0;
        sym_force = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", state, 0);
        chk("reset_loop_rst", loop_rst, 1);
        chk("reset_lock", lock, 0);
        chk("reset_gain", gain_sel, 0);
        chk("reset_sym_gate", sym_valid_out, 0);
        sym_force = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Settle, acquire, track, narrow with a constant small error.
        set_enable(1'b1);
        repeat (SETTLE_SYMS) send_err(100, GAP);
        check_mode("s1_acquire");
        repeat (LOCK_WINS) send_win_val(100);
        check_mode("s1_track");
        repeat (NARROW_WINS) send_win_val(100);
        check_mode("s1_narrow");

        // Large error in NARROW: loss of lock back to SETTLE.
        repeat (UNLOCK_WINS) send_win_val(-2000);
        check_mode("s2_unlock");

        // Re-lock, then alternate good/bad windows in TRACK.
        repeat (SETTLE_SYMS) send_err(rand_err(2), GAP);
        repeat (LOCK_WINS) send_win_val(100);
        check_mode("s3_track");
        repeat (6) begin
            send_win_val(100);
            send_win_val(2000);
        end
        check_mode("s3_alternating");

        // Randomised windows; the model follows whatever mode results.
        for (int i = 0; i < 24; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            send_win_cls((r < 5) ? 0 : ((r < 7) ? 1 : 2));
            if (i % 4 == 3) check_mode("rand_mode");
        end

        // Most negative error in ACQUIRE: saturated abs, exact sum.
        set_enable(1'b0);
        set_enable(1'b1);
        repeat (SETTLE_SYMS) send_err(rand_err(1), GAP);
        send_win_val(-(1 << (EW - 1)));
        check_mode("s4_acquire");
`ifdef CARRIER_LOCK_STATS_EN
        chk("s4_win_metric", win_metric, m_last);
`endif

        // Sample arriving in the win_done cycle opens the next window.
        send_win_cls(1);
        repeat (WIN_LEN) send_err(100, GAP);
        send_err(100, 1);
        repeat (WIN_LEN - 1) send_err(100, GAP);
        check_mode("s5_track_after_b2b");

        // Drop enable mid-window in TRACK.
        send_err(100, GAP);
        send_err(100, GAP);
        sym_force = 1'b1;
        enable = 1'b0;
        @(posedge clk); #1;
        exp_pd_en = 1'b0;
        model_enable(1'b0);
        chk("s6_state_idle", state, 0);
        chk("s6_loop_rst", loop_rst, 1);
        chk("s6_sym_gated", sym_valid_out, 0);
        sym_force = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        set_enable(1'b1);
        repeat (SETTLE_SYMS) send_err(100, GAP);
        repeat (WIN_LEN + 2) send_err(100, GAP);
        check_mode("s6_partial_discarded");
        repeat (2 * WIN_LEN - 2) send_err(100, GAP);
        check_mode("s6_relock");
`ifdef CARRIER_LOCK_STATS_EN
        chk("s6_loss_cnt", loss_cnt, m_loss);
`endif

        repeat (5) begin @(posedge clk); #1; end
        chk("pending_transitions", exp_q.size(), 0);
        mon_en = 1'b0;

        // Reset in the middle of a window.
        send_err(100, GAP);
        send_err(100, GAP);
        rst = 1'b1;
        sym_force = 1'b1;
        @(posedge clk); #1;
        chk("s7_state", state, 0);
        chk("s7_loop_rst", loop_rst, 1);
        chk("s7_lock", lock, 0);
        chk("s7_gain", gain_sel, 0);
        chk("s7_sym_gated", sym_valid_out, 0);
`ifdef CARRIER_LOCK_STATS_EN
        chk("s7_loss_cnt", loss_cnt, 0);
        chk("s7_win_metric", win_metric, 0);
`endif
        rst = 1'b0;
        sym_force = 1'b0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
